// File: rtl/print_pkg.sv
// rtl/print_pkg.sv - shared types, ASCII constants and nibble encoder for the print serialiser
package print_pkg;

  typedef enum logic [1:0] {
    PM_RAW_BE = 2'd0,
    PM_RAW_LE = 2'd1,
    PM_HEX    = 2'd2,
    PM_RSVD   = 2'd3
  } print_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ser_state_t;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Lowercase hex digit for a 4-bit value.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_0 + {4'd0, nib};
    end
    return ASCII_A_LC + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/print_serializer_if.sv
// rtl/print_serializer_if.sv - print request handshake and outgoing byte stream
interface print_serializer_if #(
  parameter int DATA_W = 32
);

  logic              REQ_VALID;
  logic              REQ_READY;
  logic [DATA_W-1:0] REQ_DATA;
  logic [1:0]        REQ_MODE;
  logic              TX_VALID;
  logic              TX_READY;
  logic [7:0]        TX_DATA;

  modport master (
    output REQ_VALID, REQ_DATA, REQ_MODE, TX_READY,
    input  REQ_READY, TX_VALID, TX_DATA
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, REQ_MODE, TX_READY,
    output REQ_READY, TX_VALID, TX_DATA
  );

endinterface

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - first-word-fallthrough byte FIFO with explicit occupancy count
module byte_fifo #(
  parameter int DEPTH = 512,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [7:0]       push_data_i,
  input  logic             pop_i,
  output logic [7:0]       pop_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // No pop-before-push bypass: a full FIFO refuses the push even when popping.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Head byte is driven straight from storage; forced to zero when empty.
  assign pop_data_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/print_serializer.sv
// rtl/print_serializer.sv - serialises print requests into bytes and buffers them for the UART
module print_serializer
  import print_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 512,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  print_serializer_if.slave bus,
  output logic [CNT_W-1:0] FIFO_COUNT,
  output logic             BUSY
);

  localparam int NB       = DATA_W / 8;
  localparam int HEX_LAST = 2 * NB;
  localparam int RAW_LAST = NB - 1;
  localparam int IDX_W    = $clog2(2 * NB + 1);

  ser_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  print_mode_t       mode_q, mode_d;
  logic              ready_en_q;

  logic              req_ready;
  logic              push;
  logic [7:0]        push_byte;
  logic [IDX_W-1:0]  last_idx;
  logic [DATA_W-1:0] sh;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_head;

  assign last_idx = (mode_q == PM_HEX) ? IDX_W'(HEX_LAST) : IDX_W'(RAW_LAST);

  // ready_en_q keeps REQ_READY low until the first clock after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      mode_q     <= PM_RAW_BE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (req_ready && bus.REQ_VALID) begin
          state_d = ST_EMIT;
          idx_d   = '0;
          data_d  = bus.REQ_DATA;
          case (bus.REQ_MODE)
            2'd1:    mode_d = PM_RAW_LE;
            2'd2:    mode_d = PM_HEX;
            default: mode_d = PM_RAW_BE;
          endcase
        end
      end
      ST_EMIT: begin
        if (!fifo_full) begin
          if (idx_q == last_idx) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE) && ready_en_q;
    push      = (state_q == ST_EMIT) && !fifo_full;
    sh        = '0;
    push_byte = 8'h00;
    case (mode_q)
      PM_RAW_LE: begin
        sh        = data_q >> (8 * int'(idx_q));
        push_byte = sh[7:0];
      end
      PM_HEX: begin
        if (idx_q == IDX_W'(HEX_LAST)) begin
          push_byte = ASCII_LF;
        end else begin
          sh        = data_q >> (4 * (2 * NB - 1 - int'(idx_q)));
          push_byte = nibble_to_ascii(sh[3:0]);
        end
      end
      default: begin
        sh        = data_q >> (8 * (NB - 1 - int'(idx_q)));
        push_byte = sh[7:0];
      end
    endcase
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_n_i     (RST_N),
    .push_i      (push),
    .push_data_i (push_byte),
    .pop_i       (bus.TX_READY),
    .pop_data_o  (fifo_head),
    .count_o     (FIFO_COUNT),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.REQ_READY = req_ready;
  assign bus.TX_VALID  = !fifo_empty;
  assign bus.TX_DATA   = fifo_head;
  assign BUSY          = (state_q == ST_EMIT) || !fifo_empty;

endmodule

// File: tb/tb_print_serializer.sv
// tb/tb_print_serializer.sv - directed self-checking bench for print_serializer
module tb_print_serializer;

  typedef logic [7:0] bq_t[$];

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [9:0] cnt_a;
  logic       busy_a;
  logic [2:0] cnt_b;
  logic       busy_b;

  int n_checks = 0;
  int n_fail   = 0;
  bq_t q_a, q_b;

  always #5 CLK = ~CLK;

  print_serializer_if #(.DATA_W(32)) if_a ();
  print_serializer_if #(.DATA_W(32)) if_b ();

  print_serializer #(.DATA_W(32), .FIFO_DEPTH(512)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .bus(if_a), .FIFO_COUNT(cnt_a), .BUSY(busy_a)
  );

  print_serializer #(.DATA_W(32), .FIFO_DEPTH(4)) u_small (
    .CLK(CLK), .RST_N(RST_N), .bus(if_b), .FIFO_COUNT(cnt_b), .BUSY(busy_b)
  );

  always @(negedge CLK) begin
    if (if_a.TX_VALID && if_a.TX_READY) q_a.push_back(if_a.TX_DATA);
    if (if_b.TX_VALID && if_b.TX_READY) q_b.push_back(if_b.TX_DATA);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cmp_q(input string tag, input bq_t got, input bq_t exp);
    check({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), (i < got.size()) ? 64'(got[i]) : 64'hDEAD, 64'(exp[i]));
    end
  endtask

  task automatic send_a(input logic [31:0] data, input logic [1:0] mode);
    if_a.REQ_DATA  = data;
    if_a.REQ_MODE  = mode;
    if_a.REQ_VALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (if_a.REQ_READY) break;
      step();
    end
    check("send_ready", if_a.REQ_READY, 1'b1);
    step();
    if_a.REQ_VALID = 1'b0;
    if_a.REQ_DATA  = 32'hFFFF_FFFF;
    if_a.REQ_MODE  = 2'd2;
  endtask

  task automatic drain_a(input string tag, input bq_t exp);
    if_a.TX_READY = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!busy_a) break;
      step();
    end
    check({tag, "_idle"}, busy_a, 1'b0);
    cmp_q(tag, q_a, exp);
    q_a.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    if_a.REQ_VALID = 0; if_a.REQ_DATA = '0; if_a.REQ_MODE = '0; if_a.TX_READY = 0;
    if_b.REQ_VALID = 0; if_b.REQ_DATA = '0; if_b.REQ_MODE = '0; if_b.TX_READY = 0;

    // Reset state
    step(); step();
    check("rst_req_ready", if_a.REQ_READY, 1'b0);
    check("rst_tx_valid", if_a.TX_VALID, 1'b0);
    check("rst_tx_data", if_a.TX_DATA, 8'h00);
    check("rst_count", cnt_a, 10'd0);
    check("rst_busy", busy_a, 1'b0);
    RST_N = 1'b1;
    step();
    check("post_rst_ready", if_a.REQ_READY, 1'b1);

    // RAW_BE with cycle-exact timing
    if_a.TX_READY = 1'b1;
    send_a(32'h1234_5678, 2'd0);
    check("be_acc_valid", if_a.TX_VALID, 1'b0);
    check("be_acc_busy", busy_a, 1'b1);
    check("be_acc_ready", if_a.REQ_READY, 1'b0);
    step();
    check("be_c1_valid", if_a.TX_VALID, 1'b1);
    check("be_c1_data", if_a.TX_DATA, 8'h12);
    step();
    check("be_c2_data", if_a.TX_DATA, 8'h34);
    step();
    check("be_c3_data", if_a.TX_DATA, 8'h56);
    check("be_c3_ready", if_a.REQ_READY, 1'b0);
    step();
    check("be_c4_data", if_a.TX_DATA, 8'h78);
    check("be_c4_ready", if_a.REQ_READY, 1'b1);
    check("be_c4_busy", busy_a, 1'b1);
    step();
    check("be_c5_busy", busy_a, 1'b0);
    check("be_c5_valid", if_a.TX_VALID, 1'b0);
    drain_a("be", '{8'h12, 8'h34, 8'h56, 8'h78});

    // RAW_LE
    send_a(32'hDEAD_BEEF, 2'd1);
    drain_a("le", '{8'hEF, 8'hBE, 8'hAD, 8'hDE});

    // HEX with the FIFO accumulating
    if_a.TX_READY = 1'b0;
    send_a(32'h00A0_FF09, 2'd2);
    for (int i = 0; i < 10; i++) step();
    check("hex_count", cnt_a, 10'd9);
    check("hex_ready", if_a.REQ_READY, 1'b1);
    check("hex_head", if_a.TX_DATA, 8'h30);
    drain_a("hex", '{8'h30, 8'h30, 8'h61, 8'h30, 8'h66, 8'h66, 8'h30, 8'h39, 8'h0A});

    // Reserved mode behaves as RAW_BE
    send_a(32'h0102_0304, 2'd3);
    drain_a("rsvd", '{8'h01, 8'h02, 8'h03, 8'h04});

    // Depth-4 FIFO: fill, stall a second request, pop once, wrap
    if_b.REQ_DATA  = 32'hAABB_CCDD;
    if_b.REQ_MODE  = 2'd0;
    if_b.REQ_VALID = 1'b1;
    check("sm_ready0", if_b.REQ_READY, 1'b1);
    step();
    if_b.REQ_VALID = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("sm_full_count", cnt_b, 3'd4);
    check("sm_full_ready", if_b.REQ_READY, 1'b1);
    check("sm_full_head", if_b.TX_DATA, 8'hAA);
    if_b.REQ_DATA  = 32'h1122_3344;
    if_b.REQ_VALID = 1'b1;
    step();
    if_b.REQ_VALID = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("sm_stall_count", cnt_b, 3'd4);
    check("sm_stall_ready", if_b.REQ_READY, 1'b0);
    check("sm_stall_busy", busy_b, 1'b1);
    if_b.TX_READY = 1'b1;
    step();
    if_b.TX_READY = 1'b0;
    check("sm_pop_count", cnt_b, 3'd3);
    check("sm_pop_head", if_b.TX_DATA, 8'hBB);
    step();
    check("sm_refill_count", cnt_b, 3'd4);
    check("sm_refill_ready", if_b.REQ_READY, 1'b0);
    if_b.TX_READY = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!busy_b) break;
      step();
    end
    check("sm_idle", busy_b, 1'b0);
    cmp_q("sm", q_b, '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44});

    // Asynchronous reset mid-HEX emission
    if_a.TX_READY = 1'b0;
    send_a(32'hCAFE_F00D, 2'd2);
    step(); step(); step();
    check("ar_count_pre", cnt_a, 10'd3);
    #3;
    RST_N = 1'b0;
    #1;
    check("ar_ready", if_a.REQ_READY, 1'b0);
    check("ar_valid", if_a.TX_VALID, 1'b0);
    check("ar_data", if_a.TX_DATA, 8'h00);
    check("ar_count", cnt_a, 10'd0);
    check("ar_busy", busy_a, 1'b0);
    step();
    RST_N = 1'b1;
    if_a.TX_READY = 1'b1;
    q_a.delete();
    step();
    check("ar_post_ready", if_a.REQ_READY, 1'b1);
    check("ar_post_valid", if_a.TX_VALID, 1'b0);
    check("ar_post_count", cnt_a, 10'd0);
    for (int i = 0; i < 5; i++) step();
    check("ar_no_output", 64'(q_a.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
